// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter                                                         |
// | Two-requester req/ack arbiter in front of a single-port synchronous      |
// | data memory: issue, read-latency wait, one-cycle ack with read data.     |
// | Optional macro ARB_FIXED_PRIO_EN: r0 wins every tie (else round-robin).  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_ack,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_ack,
    output logic [DW-1:0] r1_rdata,
    output logic          mem_en,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          last_grant
);

    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant_q, grant_d;
    logic             we_q, we_d;
    logic             last_grant_q, last_grant_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_wen_q, mem_wen_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
    logic             r0_ack_q, r0_ack_d;
    logic             r1_ack_q, r1_ack_d;
    logic [DW-1:0]    r0_rdata_q, r0_rdata_d;
    logic [DW-1:0]    r1_rdata_q, r1_rdata_d;
    logic             w_arb_g;

    // Tie-break only matters when both requesters are asking at once.
    always_comb begin
        w_arb_g = r1_req;
        if (r0_req && r1_req) begin
`ifdef ARB_FIXED_PRIO_EN
            w_arb_g = 1'b0;
`else
            w_arb_g = ~last_grant_q;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        we_d         = we_q;
        last_grant_d = last_grant_q;
        mem_en_d     = mem_en_q;
        mem_wen_d    = mem_wen_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        r0_ack_d     = 1'b0;
        r1_ack_d     = 1'b0;
        r0_rdata_d   = '0;
        r1_rdata_d   = '0;
        case (state_q)
            S_IDLE: begin
                mem_en_d  = 1'b0;
                mem_wen_d = 1'b0;
                if (r0_req || r1_req) begin
                    grant_d     = w_arb_g;
                    we_d        = w_arb_g ? r1_we    : r0_we;
                    mem_addr_d  = w_arb_g ? r1_addr  : r0_addr;
                    mem_wdata_d = w_arb_g ? r1_wdata : r0_wdata;
                    mem_en_d    = 1'b1;
                    mem_wen_d   = w_arb_g ? r1_we : r0_we;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_en_d  = 1'b0;
                mem_wen_d = 1'b0;
                if (we_q) begin
                    r0_ack_d = ~grant_q;
                    r1_ack_d = grant_q;
                    state_d  = S_DONE;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    r0_ack_d   = ~grant_q;
                    r1_ack_d   = grant_q;
                    r0_rdata_d = grant_q ? '0 : mem_rdata;
                    r1_rdata_d = grant_q ? mem_rdata : '0;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                last_grant_d = grant_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            last_grant_q <= 1'b1;
            mem_en_q     <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            r0_ack_q     <= 1'b0;
            r1_ack_q     <= 1'b0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            last_grant_q <= last_grant_d;
            mem_en_q     <= mem_en_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            r0_ack_q     <= r0_ack_d;
            r1_ack_q     <= r1_ack_d;
            r0_rdata_q   <= r0_rdata_d;
            r1_rdata_q   <= r1_rdata_d;
        end
    end

    assign r0_ack     = r0_ack_q;
    assign r1_ack     = r1_ack_q;
    assign r0_rdata   = r0_rdata_q;
    assign r1_rdata   = r1_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_wen    = mem_wen_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = (state_q != S_IDLE);
    assign last_grant = last_grant_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                      |
// | Two arbiter instances (RD_LAT=1 and RD_LAT=3) with latency-accurate      |
// | memory models; directed vectors, corner sequences and a random run.      |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // [instance][requester]
    logic [1:0][1:0]       req_v, we_v, ack_o;
    logic [1:0][1:0][31:0] addr_v, wdata_v, rdata_o;
    logic [1:0]            mem_en, mem_wen, busy, last_grant;
    logic [1:0][31:0]      mem_addr, mem_wdata, mem_rdata;
    logic [31:0]           mem  [2][256];
    logic [31:0]           pipe [2][4];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          inst;
        logic        q0, q1, we0, we1;
        logic [31:0] a0, d0, a1, d1;
        int          exp_g;
        int          exp_cyc;
        logic [31:0] exp_rd;
    } vec_t;

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] init_word(int k, int i);
        if (k == 1 && i == 'h20) return 32'h1234_5678;
        return 32'hA500_0000 | 32'(k << 8) | 32'(i);
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT((k == 0) ? 1 : 3)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .r0_req    (req_v[k][0]),
            .r0_we     (we_v[k][0]),
            .r0_addr   (addr_v[k][0]),
            .r0_wdata  (wdata_v[k][0]),
            .r0_ack    (ack_o[k][0]),
            .r0_rdata  (rdata_o[k][0]),
            .r1_req    (req_v[k][1]),
            .r1_we     (we_v[k][1]),
            .r1_addr   (addr_v[k][1]),
            .r1_wdata  (wdata_v[k][1]),
            .r1_ack    (ack_o[k][1]),
            .r1_rdata  (rdata_o[k][1]),
            .mem_en    (mem_en[k]),
            .mem_wen   (mem_wen[k]),
            .mem_addr  (mem_addr[k]),
            .mem_wdata (mem_wdata[k]),
            .mem_rdata (mem_rdata[k]),
            .busy      (busy[k]),
            .last_grant(last_grant[k])
        );
        assign mem_rdata[k] = pipe[k][(k == 0) ? 0 : 2];
    end

    // BRAM models: read data shows up lat_of(k) edges after the sampling edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int i = 0; i < 256; i++) mem[k][i] <= init_word(k, i);
            end else if (mem_en[k] && mem_wen[k]) begin
                mem[k][mem_addr[k][7:0]] <= mem_wdata[k];
            end
            pipe[k][0] <= (!reset && mem_en[k] && !mem_wen[k]) ? mem[k][mem_addr[k][7:0]]
                                                                : 32'hBAD0_0000;
            for (int s = 1; s < 4; s++) pipe[k][s] <= pipe[k][s-1];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(int inst, logic q0, logic q1, logic we0, logic we1,
                                logic [31:0] a0, logic [31:0] d0, logic [31:0] a1,
                                logic [31:0] d1, int g, int cyc, logic [31:0] rd);
        vec_t v;
        v.inst = inst; v.q0 = q0; v.q1 = q1; v.we0 = we0; v.we1 = we1;
        v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.exp_g = g; v.exp_cyc = cyc; v.exp_rd = rd;
        return v;
    endfunction

    task automatic clear_drives();
        req_v = '0; we_v = '0; addr_v = '0; wdata_v = '0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b1;
        clear_drives();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One access from idle; reqs dropped during the ack cycle.
    task automatic run_vec(input vec_t v);
        int k, got_cyc, en_cnt, other_ack, g;
        logic [31:0] got_rd;
        k = v.inst; got_cyc = 0; en_cnt = 0; other_ack = 0; got_rd = '0;
        g = v.exp_g;
        @(negedge clk);
        req_v[k][0] = v.q0; we_v[k][0] = v.we0; addr_v[k][0] = v.a0; wdata_v[k][0] = v.d0;
        req_v[k][1] = v.q1; we_v[k][1] = v.we1; addr_v[k][1] = v.a1; wdata_v[k][1] = v.d1;
        for (int c = 1; c <= 12 && got_cyc == 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_en[k]) begin
                en_cnt++;
                check("vec_mem_addr", mem_addr[k], (g == 0) ? v.a0 : v.a1);
                check("vec_mem_wen", 32'(mem_wen[k]), 32'((g == 0) ? v.we0 : v.we1));
                if ((g == 0) ? v.we0 : v.we1)
                    check("vec_mem_wdata", mem_wdata[k], (g == 0) ? v.d0 : v.d1);
            end
            if (ack_o[k][1-g]) other_ack = 1;
            if (ack_o[k][g]) begin
                got_cyc = c;
                got_rd  = rdata_o[k][g];
                check("vec_other_rdata", rdata_o[k][1-g], 32'h0);
                req_v[k] = '0;
            end
        end
        req_v[k] = '0;
        check("vec_ack_cycle", 32'(got_cyc), 32'(v.exp_cyc));
        check("vec_rdata", got_rd, v.exp_rd);
        check("vec_other_ack", 32'(other_ack), 32'h0);
        check("vec_mem_en_cycles", 32'(en_cnt), 32'h1);
        @(posedge clk);
        @(negedge clk);
        check("vec_idle_busy", 32'(busy[k]), 32'h0);
        check("vec_last_grant", 32'(last_grant[k]), 32'(g));
    endtask

    // Reference model state for the random run.
    bit          m_act  [2];
    int          m_t    [2];
    int          m_lat  [2];
    bit          m_g    [2];
    bit          m_we   [2];
    bit          m_last [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd   [2];
    logic [31:0] m_rd   [2];
    logic [31:0] gm     [2][256];

    vec_t tv [7];

    initial begin : main
        int cyc, n_ack, g, prev_g, bad;
        bit prev_ack;
        clear_drives();

        tv[0] = mk(0, 1, 0, 1, 0, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 2, 32'h0);
        tv[1] = mk(0, 1, 0, 0, 0, 32'h10, 0, 0, 0, 0, 3, 32'hDEAD_BEEF);
        tv[2] = mk(0, 0, 1, 0, 1, 32'h77, 32'h1, 32'h20, 32'hCAFE_F00D, 1, 2, 32'h0);
        tv[3] = mk(0, 1, 1, 0, 0, 32'h10, 0, 32'h20, 0, 0, 3, 32'hDEAD_BEEF);
        tv[4] = mk(0, 1, 1, 0, 0, 32'h10, 0, 32'h20, 0, FIXED ? 0 : 1, 3,
                   FIXED ? 32'hDEAD_BEEF : 32'hCAFE_F00D);
        tv[5] = mk(1, 0, 1, 0, 0, 32'h5, 0, 32'h20, 0, 1, 5, 32'h1234_5678);
        tv[6] = mk(1, 1, 0, 1, 1, 32'h33, 32'h0BAD_CAFE, 32'hFFFF, 32'h9, 0, 2, 32'h0);

        // Asynchronous reset before any clock edge.
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_ctl", {26'h0, ack_o[k], mem_en[k], mem_wen[k], busy[k], last_grant[k]},
                  32'h1);
            check("rst_rdata", rdata_o[k][0] | rdata_o[k][1], 32'h0);
        end
        req_v = '1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_mem_en_held", {30'h0, mem_en}, 32'h0);
        end
        clear_drives();
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(tv[i]);

        // Both requesters hold reads for four accesses.
        reset_pulse();
        @(negedge clk);
        req_v[0] = 2'b11; we_v[0] = 2'b00;
        addr_v[0][0] = 32'h10; addr_v[0][1] = 32'h20;
        n_ack = 0; cyc = 0; prev_ack = 0; prev_g = 0;
        while (n_ack < 4 && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (prev_ack) begin
                check("both_bubble_busy", 32'(busy[0]), 32'h0);
                check("both_last_grant", 32'(last_grant[0]), 32'(prev_g));
                prev_ack = 0;
            end
            if (ack_o[0] != 2'b00) begin
                g = int'(ack_o[0][1]);
                check("both_single_ack", 32'(ack_o[0][0] & ack_o[0][1]), 32'h0);
                check("both_grant", 32'(g), FIXED ? 32'h0 : 32'(n_ack % 2));
                check("both_ack_cycle", 32'(cyc), 32'(3 + 4 * n_ack));
                check("both_rdata", rdata_o[0][g], init_word(0, (g == 1) ? 'h20 : 'h10));
                n_ack++;
                prev_ack = 1;
                prev_g = g;
            end
        end
        req_v[0] = '0;
        check("both_acks_seen", 32'(n_ack), 32'h4);

        // Reset while a read is waiting on memory.
        reset_pulse();
        @(negedge clk);
        req_v[1][0] = 1'b1; we_v[1][0] = 1'b0; addr_v[1][0] = 32'h20;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("wait_busy_before", 32'(busy[1]), 32'h1);
        #1 reset = 1'b1;
        req_v[1] = '0;
        #1;
        check("wait_rst_ctl", {26'h0, ack_o[1], mem_en[1], mem_wen[1], busy[1], last_grant[1]},
              32'h1);
        check("wait_rst_rdata", rdata_o[1][0] | rdata_o[1][1], 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack_o[1] != 2'b00 || busy[1]) bad++;
        end
        check("wait_rst_no_ack", 32'(bad), 32'h0);
        run_vec(mk(1, 1, 0, 0, 0, 32'h20, 0, 0, 0, 0, 5, 32'h1234_5678));

        // Random traffic against a transaction-level reference model.
        reset_pulse();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_t[k] = 0; m_lat[k] = 0; m_g[k] = 0; m_we[k] = 0;
            m_last[k] = 1; m_addr[k] = '0; m_wd[k] = '0; m_rd[k] = '0;
            for (int i = 0; i < 256; i++) gm[k][i] = init_word(k, i);
        end
        for (int cy = 0; cy < 1500; cy++) begin
            for (int k = 0; k < 2; k++) begin
                bit e_en;
                logic [1:0] e_ack;
                logic [31:0] e_rd;
                e_en  = m_act[k] && m_t[k] == 1;
                e_ack = '0;
                if (m_act[k] && m_t[k] == m_lat[k]) e_ack[m_g[k]] = 1'b1;
                e_rd  = (e_ack != 2'b00 && !m_we[k]) ? m_rd[k] : 32'h0;
                check("rnd_ctl", {26'h0, busy[k], mem_en[k], mem_wen[k], last_grant[k], ack_o[k]},
                      {26'h0, m_act[k], e_en, e_en & m_we[k], m_last[k], e_ack});
                check("rnd_r0_rdata", rdata_o[k][0], e_ack[0] ? e_rd : 32'h0);
                check("rnd_r1_rdata", rdata_o[k][1], e_ack[1] ? e_rd : 32'h0);
                if (e_en) begin
                    check("rnd_mem_addr", mem_addr[k], m_addr[k]);
                    if (m_we[k]) check("rnd_mem_wdata", mem_wdata[k], m_wd[k]);
                end
                for (int j = 0; j < 2; j++) begin
                    if (!req_v[k][j]) begin
                        if ($urandom_range(0, 2) == 0) begin
                            req_v[k][j]   = 1'b1;
                            we_v[k][j]    = 1'($urandom_range(0, 1));
                            addr_v[k][j]  = $urandom() & 32'hFFFF_FF07;
                            wdata_v[k][j] = $urandom();
                        end
                    end else if (ack_o[k][j]) begin
                        if ($urandom_range(0, 1) == 0) begin
                            req_v[k][j] = 1'b0;
                        end else begin
                            we_v[k][j]    = 1'($urandom_range(0, 1));
                            addr_v[k][j]  = $urandom() & 32'hFFFF_FF07;
                            wdata_v[k][j] = $urandom();
                        end
                    end
                end
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (m_act[k]) begin
                    m_t[k]++;
                    if (m_t[k] > m_lat[k]) begin
                        m_act[k]  = 0;
                        m_last[k] = m_g[k];
                    end
                end else if (req_v[k] != 2'b00) begin
                    if (req_v[k] == 2'b11) m_g[k] = FIXED ? 1'b0 : ~m_last[k];
                    else                   m_g[k] = req_v[k][1];
                    m_act[k]  = 1;
                    m_t[k]    = 1;
                    m_we[k]   = we_v[k][m_g[k]];
                    m_addr[k] = addr_v[k][m_g[k]];
                    m_wd[k]   = wdata_v[k][m_g[k]];
                    m_lat[k]  = m_we[k] ? 2 : 2 + lat_of(k);
                    if (m_we[k]) gm[k][m_addr[k][7:0]] = m_wd[k];
                    else         m_rd[k] = gm[k][m_addr[k][7:0]];
                end
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
